// File: rtl/axi_lite_master_arbiter_pkg.sv
// Shared definitions for the two-requester AXI-Lite master arbiter.
package axi_lite_master_arbiter_pkg;

  // Number of upstream requesters sharing the single master port
  localparam int NUM_REQ = 2;

  // Master-port transaction FSM; only one transaction is in flight at a time
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_ADDR      = 3'd1,
    ST_RD_DATA      = 3'd2,
    ST_WR_ADDR_DATA = 3'd3,
    ST_WR_RESP      = 3'd4
  } state_t;

  // One-hot select vector for a requester index
  function automatic logic [NUM_REQ-1:0] onehot_req(input logic idx);
    return {idx, ~idx};
  endfunction

endpackage

// File: rtl/axi_lite_master_arbiter_rr.sv
// Two-way round-robin grant logic, purely combinational.
module rr_arbiter_2
  import axi_lite_master_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic               i_last,
  output logic               o_grant_vld,
  output logic               o_grant_idx
);

  // On a tie the requester not served last wins; a lone requester always wins
  always_comb begin
    o_grant_vld = |i_pending;
    o_grant_idx = 1'b0;
    if (&i_pending) begin
      o_grant_idx = ~i_last;
    end else if (i_pending[1]) begin
      o_grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI-Lite master port between two requesters, one transaction at
// a time. Address/data are muxed from the granted requester, never stored.
module axi_lite_master_arbiter
  import axi_lite_master_arbiter_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  // Requester-side read address / data
  input  logic [NUM_REQ-1:0]          s_arvalid,
  output logic [NUM_REQ-1:0]          s_arready,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_araddr,
  output logic [NUM_REQ-1:0]          s_rvalid,
  input  logic [NUM_REQ-1:0]          s_rready,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [1:0]                  s_rresp,
  // Requester-side write address / data / response
  input  logic [NUM_REQ-1:0]          s_awvalid,
  output logic [NUM_REQ-1:0]          s_awready,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_REQ-1:0]          s_wvalid,
  output logic [NUM_REQ-1:0]          s_wready,
  input  logic [NUM_REQ*DATA_W-1:0]   s_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]   s_wstrb,
  output logic [NUM_REQ-1:0]          s_bvalid,
  input  logic [NUM_REQ-1:0]          s_bready,
  output logic [1:0]                  s_bresp,
  // Shared master port
  output logic                        m_axi_arvalid,
  output logic [ADDR_W-1:0]           m_axi_araddr,
  input  logic                        m_axi_arready,
  input  logic                        m_axi_rvalid,
  input  logic [DATA_W-1:0]           m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  output logic                        m_axi_rready,
  output logic                        m_axi_awvalid,
  output logic [ADDR_W-1:0]           m_axi_awaddr,
  input  logic                        m_axi_awready,
  output logic                        m_axi_wvalid,
  output logic [DATA_W-1:0]           m_axi_wdata,
  output logic [STRB_W-1:0]           m_axi_wstrb,
  input  logic                        m_axi_wready,
  input  logic                        m_axi_bvalid,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_bready
);

  state_t               r_state;
  logic                 r_gnt;      // requester owning the current transaction
  logic                 r_last;     // requester most recently completed
  logic                 r_aw_done;
  logic                 r_w_done;

  logic [NUM_REQ-1:0]   w_pending;
  logic [NUM_REQ-1:0]   w_gnt_oh;
  logic                 w_arb_vld;
  logic                 w_arb_idx;
  logic                 w_ar_hs;
  logic                 w_r_hs;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_b_hs;
  logic                 w_aw_fin;
  logic                 w_w_fin;

  // A write only counts as pending once both its address and data are offered
  assign w_pending = s_arvalid | (s_awvalid & s_wvalid);

  rr_arbiter_2 u_rr (
    .i_pending   (w_pending),
    .i_last      (r_last),
    .o_grant_vld (w_arb_vld),
    .o_grant_idx (w_arb_idx)
  );

  assign w_gnt_oh = onehot_req(r_gnt);

  // Master-side valids/readies decode from the registered state, so all are
  // low in IDLE and each write valid drops once its own handshake is done.
  assign m_axi_arvalid = (r_state == ST_RD_ADDR);
  assign m_axi_rready  = (r_state == ST_RD_DATA) & s_rready[r_gnt];
  assign m_axi_awvalid = (r_state == ST_WR_ADDR_DATA) & ~r_aw_done;
  assign m_axi_wvalid  = (r_state == ST_WR_ADDR_DATA) & ~r_w_done;
  assign m_axi_bready  = (r_state == ST_WR_RESP) & s_bready[r_gnt];

  // Payload muxed straight from the granted requester's slice
  assign m_axi_araddr = r_gnt ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
  assign m_axi_awaddr = r_gnt ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
  assign m_axi_wdata  = r_gnt ? s_wdata[2*DATA_W-1:DATA_W]  : s_wdata[DATA_W-1:0];
  assign m_axi_wstrb  = r_gnt ? s_wstrb[2*STRB_W-1:STRB_W]  : s_wstrb[STRB_W-1:0];

  // Handshake steering: only the granted requester ever sees a ready/valid
  assign s_arready = w_gnt_oh & {NUM_REQ{m_axi_arvalid & m_axi_arready}};
  assign s_awready = w_gnt_oh & {NUM_REQ{m_axi_awvalid & m_axi_awready}};
  assign s_wready  = w_gnt_oh & {NUM_REQ{m_axi_wvalid & m_axi_wready}};
  assign s_rvalid  = w_gnt_oh & {NUM_REQ{(r_state == ST_RD_DATA) & m_axi_rvalid}};
  assign s_bvalid  = w_gnt_oh & {NUM_REQ{(r_state == ST_WR_RESP) & m_axi_bvalid}};

  // Responses pass through untouched, error codes included
  assign s_rdata = m_axi_rdata;
  assign s_rresp = m_axi_rresp;
  assign s_bresp = m_axi_bresp;

  assign w_ar_hs  = m_axi_arvalid & m_axi_arready;
  assign w_r_hs   = m_axi_rvalid & m_axi_rready;
  assign w_aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_w_hs   = m_axi_wvalid & m_axi_wready;
  assign w_b_hs   = m_axi_bvalid & m_axi_bready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  // Transaction FSM: arbitrate in IDLE, then walk one read or one write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_vld) begin
            r_gnt   <= w_arb_idx;
            r_state <= s_arvalid[w_arb_idx] ? ST_RD_ADDR : ST_WR_ADDR_DATA;
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_hs) r_state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (w_r_hs) begin
            r_state <= ST_IDLE;
            r_last  <= r_gnt;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (w_aw_fin && w_w_fin) begin
            r_state   <= ST_WR_RESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (w_b_hs) begin
            r_state <= ST_IDLE;
            r_last  <= r_gnt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Bench for the two-requester AXI-Lite arbiter: directed scenarios followed
// by random request streams, checked against a round-robin service model.
module tb_axi_lite_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
  logic [2*AW-1:0] s_araddr, s_awaddr;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp, s_bresp;
  logic [1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [2*DW-1:0] s_wdata;
  logic [2*SW-1:0] s_wstrb;
  logic            m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [AW-1:0]   m_axi_araddr, m_axi_awaddr;
  logic [DW-1:0]   m_axi_rdata, m_axi_wdata;
  logic [1:0]      m_axi_rresp, m_axi_bresp;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [SW-1:0]   m_axi_wstrb;
  logic            m_axi_bvalid, m_axi_bready;

  axi_lite_master_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rready(m_axi_rready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or read data the slave returns
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          d1;     // AR or AW ready delay
    int          d2;     // R valid delay or W ready delay
    int          d3;     // B valid delay
  } txn_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   m_last = 1;      // model: requester most recently served
  txn_t q0[$];
  txn_t q1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk(tag, 64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready,
                  s_arready, s_awready, s_wready, s_rvalid, s_bvalid}), 64'd0);
  endtask

  function automatic txn_t mk(input bit rd, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] r,
                              input int d1, input int d2, input int d3);
    txn_t t;
    t.rd = rd; t.addr = a; t.data = d; t.strb = s; t.resp = r;
    t.d1 = d1; t.d2 = d2; t.d3 = d3;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 2'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  task automatic present(input int g, input txn_t t);
    if (t.rd) begin
      s_araddr[g*AW +: AW] = t.addr;
      s_arvalid[g] = 1'b1;
    end else begin
      s_awaddr[g*AW +: AW] = t.addr;
      s_wdata[g*DW +: DW]  = t.data;
      s_wstrb[g*SW +: SW]  = t.strb;
      s_awvalid[g] = 1'b1;
      s_wvalid[g]  = 1'b1;
    end
  endtask

  // Acts as slave for one read expected from requester g; entered in IDLE
  task automatic serve_read(input int g, input txn_t t);
    int cyc = 0, seen = -1, rcnt = 0;
    bit ard = 0, done = 0, hs_a, hs_r;
    logic [1:0] oh;
    oh = (g == 0) ? 2'b01 : 2'b10;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      hs_a = 0; hs_r = 0;
      if (cyc == 0) check_idle("rd_idle");
      if (!ard) begin
        chk("rd_no_aw_w", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
        if (m_axi_arvalid) begin
          if (seen < 0) begin seen = cyc; chk("rd_latency", 64'(cyc), 64'd1); end
          chk("araddr", 64'(m_axi_araddr), 64'(t.addr));
          chk("s_arready", 64'(s_arready), 64'(m_axi_arready ? oh : 2'b00));
          hs_a = m_axi_arready;
        end
      end else begin
        chk("s_rvalid", 64'(s_rvalid), 64'(m_axi_rvalid ? oh : 2'b00));
        chk("m_rready", 64'(m_axi_rready), 64'(s_rready[g]));
        if (m_axi_rvalid) begin
          chk("s_rdata", 64'(s_rdata), 64'(t.data));
          chk("s_rresp", 64'(s_rresp), 64'(t.resp));
        end
        hs_r = m_axi_rvalid && m_axi_rready;
      end
      @(posedge clk); #1;
      s_rready = 2'($urandom);
      if (!ard) begin
        if (hs_a) begin
          ard = 1; s_arvalid[g] = 1'b0; m_axi_arready = 1'b0;
        end else if (seen >= 0 && cyc - seen >= t.d1) begin
          m_axi_arready = 1'b1;
        end
      end else if (hs_r) begin
        m_axi_rvalid = 1'b0; done = 1;
      end else if (!m_axi_rvalid) begin
        if (rcnt >= t.d2) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = t.data; m_axi_rresp = t.resp;
        end
        rcnt++;
      end
      cyc++;
    end
    chk("rd_complete", 64'(done), 64'd1);
  endtask

  // Acts as slave for one write expected from requester g; entered in IDLE
  task automatic serve_write(input int g, input txn_t t);
    int cyc = 0, seen = -1, bcnt = 0;
    bit awd = 0, wd = 0, done = 0, hs_aw, hs_w, hs_b;
    logic [1:0] oh;
    oh = (g == 0) ? 2'b01 : 2'b10;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      hs_aw = 0; hs_w = 0; hs_b = 0;
      if (cyc == 0) check_idle("wr_idle");
      if (!(awd && wd)) begin
        chk("wr_no_ar", 64'(m_axi_arvalid), 64'd0);
        if (seen < 0 && (m_axi_awvalid || m_axi_wvalid)) begin
          seen = cyc; chk("wr_latency", 64'(cyc), 64'd1);
        end
        if (awd) chk("aw_dropped", 64'(m_axi_awvalid), 64'd0);
        else if (m_axi_awvalid) begin
          chk("awaddr", 64'(m_axi_awaddr), 64'(t.addr));
          chk("s_awready", 64'(s_awready), 64'(m_axi_awready ? oh : 2'b00));
          hs_aw = m_axi_awready;
        end
        if (wd) chk("w_dropped", 64'(m_axi_wvalid), 64'd0);
        else if (m_axi_wvalid) begin
          chk("wdata", 64'(m_axi_wdata), 64'(t.data));
          chk("wstrb", 64'(m_axi_wstrb), 64'(t.strb));
          chk("s_wready", 64'(s_wready), 64'(m_axi_wready ? oh : 2'b00));
          hs_w = m_axi_wready;
        end
      end else begin
        chk("s_bvalid", 64'(s_bvalid), 64'(m_axi_bvalid ? oh : 2'b00));
        chk("m_bready", 64'(m_axi_bready), 64'(s_bready[g]));
        if (m_axi_bvalid) chk("s_bresp", 64'(s_bresp), 64'(t.resp));
        hs_b = m_axi_bvalid && m_axi_bready;
      end
      @(posedge clk); #1;
      s_bready = 2'($urandom);
      if (!(awd && wd)) begin
        if (hs_aw) begin
          awd = 1; s_awvalid[g] = 1'b0; m_axi_awready = 1'b0;
        end else if (!awd && seen >= 0 && cyc - seen >= t.d1) begin
          m_axi_awready = 1'b1;
        end
        if (hs_w) begin
          wd = 1; s_wvalid[g] = 1'b0; m_axi_wready = 1'b0;
        end else if (!wd && seen >= 0 && cyc - seen >= t.d2) begin
          m_axi_wready = 1'b1;
        end
      end else if (hs_b) begin
        m_axi_bvalid = 1'b0; done = 1;
      end else if (!m_axi_bvalid) begin
        if (bcnt >= t.d3) begin
          m_axi_bvalid = 1'b1; m_axi_bresp = t.resp;
        end
        bcnt++;
      end
      cyc++;
    end
    chk("wr_complete", 64'(done), 64'd1);
  endtask

  task automatic serve(input int g, input txn_t t);
    if (t.rd) serve_read(g, t);
    else      serve_write(g, t);
    m_last = g;
  endtask

  // Model: each requester offers its queue head; ties go to the one not served last
  task automatic run_queues();
    txn_t t;
    int   g;
    if (q0.size() > 0) present(0, q0[0]);
    if (q1.size() > 0) present(1, q1[0]);
    while (q0.size() > 0 || q1.size() > 0) begin
      if (q0.size() > 0 && q1.size() > 0) g = 1 - m_last;
      else if (q0.size() > 0)             g = 0;
      else                                g = 1;
      if (g == 0) t = q0.pop_front();
      else        t = q1.pop_front();
      serve(g, t);
      if (g == 0 && q0.size() > 0) present(0, q0[0]);
      if (g == 1 && q1.size() > 0) present(1, q1[0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
    s_araddr = '0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
    s_rready = 2'b11; s_bready = 2'b11;
    m_axi_arready = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_rdata = '0; m_axi_rresp = '0; m_axi_bresp = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_last = 1;
    @(negedge clk);
    check_idle("reset_idle");
    @(posedge clk); #1;
  endtask

  initial begin
    txn_t t;
    bit   hs;

    // Reset state, with slave readies high to expose any leakage
    do_reset();

    // Lone requester 0 read; latency is checked inside the slave task
    t = mk(1, 32'h8000_0000, 32'hDEADBEEF, 4'h0, 2'b00, 0, 0, 0);
    present(0, t);
    serve(0, t);

    // Both read right after reset: 0 first, then strict alternation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1, 32'h0000_0100 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'h0, 2'b00, i, 1, 0));
      q1.push_back(mk(1, 32'h0000_0200 + 32'(i * 4), 32'h2000_0000 + 32'(i), 4'h0, 2'b00, 1, i, 0));
    end
    run_queues();

    // Requester 1 write, AW accepted two cycles before W
    q1.push_back(mk(0, 32'h1000_0004, 32'hA5A5A5A5, 4'hF, 2'b00, 0, 2, 1));
    run_queues();

    // Requester 0 offers read and write together: read goes first
    t = mk(1, 32'h3000_0000, 32'h0BAD_F00D, 4'h0, 2'b00, 1, 0, 0);
    present(0, t);
    present(0, mk(0, 32'h3000_0040, 32'h5555_AAAA, 4'h3, 2'b01, 1, 0, 0));
    serve(0, t);
    serve(0, mk(0, 32'h3000_0040, 32'h5555_AAAA, 4'h3, 2'b01, 1, 0, 0));

    // Slave error response on a read passes through to the granted requester
    q1.push_back(mk(1, 32'h4000_0008, 32'hCAFE_0001, 4'h0, 2'b10, 0, 1, 0));
    run_queues();

    // Reset while waiting for read data abandons the transaction
    t = mk(1, 32'h2000_0000, 32'h1234_5678, 4'h0, 2'b00, 0, 0, 0);
    present(0, t);
    m_axi_arready = 1'b1;
    hs = 0;
    for (int i = 0; i < 10 && !hs; i++) begin
      @(negedge clk);
      if (m_axi_arvalid && m_axi_arready) hs = 1;
      @(posedge clk); #1;
    end
    chk("rst_ar_handshake", 64'(hs), 64'd1);
    s_arvalid = '0; m_axi_arready = 1'b0; s_rready = 2'b11; m_axi_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_in_rd_data", 64'(m_axi_rready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check_idle("rst_mid_idle");
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0;
    t = mk(1, 32'h2000_0010, 32'h8765_4321, 4'h0, 2'b00, 2, 1, 0);
    present(0, t);
    serve(0, t);

    // Random request streams from both requesters
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        q0.push_back(rand_txn());
        q1.push_back(rand_txn());
      end
      q1.push_back(rand_txn());
      run_queues();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_arbiter.md
AXI_LITE_MASTER_ARBITER -- requirements
Module: axi_lite_master_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; STRB_W = DATA_W/8.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_arvalid / s_arready  in / out  2  per-requester read-address handshake (bit i = requester i).
REQ-006 s_araddr  input  2*ADDR_W  read addresses, requester i at slice i.
REQ-007 s_rvalid / s_rready  out / in  2  per-requester read-data handshake.
REQ-008 s_rdata, s_rresp  output  DATA_W, 2  read data/response, broadcast to both requesters, qualified by s_rvalid.
REQ-009 s_awvalid / s_awready  in / out  2  per-requester write-address handshake.
REQ-010 s_awaddr  input  2*ADDR_W  write addresses, requester i at slice i.
REQ-011 s_wvalid / s_wready  in / out  2  per-requester write-data handshake.
REQ-012 s_wdata, s_wstrb  input  2*DATA_W, 2*STRB_W  write data/strobes per requester.
REQ-013 s_bvalid / s_bready  out / in  2  per-requester write-response handshake; s_bresp  output  2  broadcast.
REQ-014 m_axi_arvalid, m_axi_araddr / m_axi_arready  out / in  1, ADDR_W / 1  shared AR channel.
REQ-015 m_axi_rvalid, m_axi_rdata, m_axi_rresp / m_axi_rready  in / out  1, DATA_W, 2 / 1  shared R channel.
REQ-016 m_axi_awvalid, m_axi_awaddr / m_axi_awready  out / in  1, ADDR_W / 1  shared AW channel.
REQ-017 m_axi_wvalid, m_axi_wdata, m_axi_wstrb / m_axi_wready  out / in  1, DATA_W, STRB_W / 1  shared W channel.
REQ-018 m_axi_bvalid, m_axi_bresp / m_axi_bready  in / out  1, 2 / 1  shared B channel.

Function
REQ-019 One transaction outstanding on the master port at a time; FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP.
REQ-020 Requester i is pending when s_arvalid[i] or (s_awvalid[i] and s_wvalid[i]).
REQ-021 In IDLE, the arbiter grants round-robin: the requester not most recently served wins when both are pending; a lone pending requester always wins.
REQ-022 Within the granted requester, a read wins over a write when both are pending.
REQ-023 Grant registered in cycle N; m_axi_arvalid or m_axi_awvalid/m_axi_wvalid asserted from cycle N+1 (one-cycle arbitration latency).
REQ-024 Address, data and strobe are muxed combinationally from the granted slice; no copies are stored.
REQ-025 RD_ADDR: m_axi_arvalid=1, s_arready[g]=m_axi_arready; go to RD_DATA on m_axi_arvalid and m_axi_arready.
REQ-026 RD_DATA: s_rvalid[g]=m_axi_rvalid, m_axi_rready=s_rready[g]; on the R handshake go to IDLE and mark g most recently served.
REQ-027 WR_ADDR_DATA: AW and W handshake independently; each valid drops once its handshake completes; go to WR_RESP when both are done (same or different cycles).
REQ-028 WR_RESP: s_bvalid[g]=m_axi_bvalid, m_axi_bready=s_bready[g]; on the B handshake go to IDLE and update round-robin.
REQ-029 All non-granted s_*ready and s_*valid outputs SHALL be 0; all m_axi valids/readies SHALL be 0 in IDLE.
REQ-030 Responses are passed through unmodified, including SLVERR/DECERR.
REQ-031 A request withdrawn before grant is ignored; after grant, valid stability is the requester's duty and is not checked.

Reset
REQ-032 On rst: FSM to IDLE, last-served pointer to requester 1 (requester 0 wins the first tie), AW/W done flags cleared, all valid/ready outputs 0.
REQ-033 rst asserted mid-transaction abandons it immediately; no completion is signalled to either requester.

Structure
REQ-034 Shared package: FSM state enum and the requester-count constant (2).
REQ-035 One sub-module: rr_arbiter_2 (pending[1:0], last-served in, grant out; combinational).

Verification
REQ-036 Only requester 0 reads 0x8000_0000, slave returns 0xDEADBEEF/OKAY -> s_rvalid=2'b01, s_rdata=0xDEADBEEF, m_axi_arvalid rises one cycle after s_arvalid.
REQ-037 Both requesters read in the same cycle after reset -> requester 0 served first, then 1; three back-to-back rounds alternate 0,1,0,1,...
REQ-038 Requester 1 writes 0x1000_0004 data 0xA5A5A5A5 strb 0xF, slave accepts AW two cycles before W -> one B, s_bvalid=2'b10, bresp=OKAY.
REQ-039 Requester 0 asserts both read and write -> read completes first, write issued in the next arbitration.
REQ-040 Slave returns rresp=2'b10 -> s_rresp=2'b10 on the granted requester only.
REQ-041 rst asserted in RD_DATA -> next cycle state IDLE, all valids 0; a later request from requester 0 is granted normally.
